jk_ff_bank: RTL and testbench
=============================

# jk_ff_bank

Parametrised bank of WIDTH independent flip-flops. Each bit runs as a JK, D, T or SR flip-flop, chosen per cycle by a shared mode input. Adds clock enable, synchronous parallel load, SR-illegal detection and a saturating change counter. Used in control and status logic where several single-bit storage elements share a clock and need common load and observation.

## Interface
Parameters:
- WIDTH, 8, number of flip-flops in the bank (≥1).
- RESET_VAL, {WIDTH{1'b0}}, value of q after reset.
- CNT_W, 16, width of change counter chg_cnt (≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  clock enable for mode-based update.
- mode  input  2  00 JK, 01 D, 10 T, 11 SR; applies to all bits.
- j  input  WIDTH  J (JK), D (D), T (T), S (SR) per bit.
- k  input  WIDTH  K (JK), R (SR); ignored in D and T modes.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- clr_err  input  1  clears err_sticky.
- q  output  WIDTH  flip-flop state, registered.
- qbar  output  WIDTH  registered complement of q.
- chg  output  WIDTH  registered per-bit flag: bit changed on the last edge.
- sr_err  output  1  registered one-cycle pulse for an illegal SR input.
- err_sticky  output  1  latched sr_err; held until clr_err or rst.
- chg_cnt  output  CNT_W  saturating count of edges on which q changed.

## Operation
- Priority at each edge: rst > load > en > hold.
- rst=1 sets: q=RESET_VAL, qbar=~RESET_VAL, chg=0, sr_err=0, err_sticky=0, chg_cnt=0. All other inputs are ignored.
- load=1 (rst=0) sets q=load_val regardless of en and mode. sr_err=0.
- en=1, load=0: each bit i updates by mode.
  - JK: {j,k}=00 hold, 01 →0, 10 →1, 11 →~q[i].
  - D: q[i]=j[i].
  - T: j[i]=1 →~q[i], else hold.
  - SR: {s,r}=00 hold, 10 →1, 01 →0, 11 hold (illegal).
- en=0, load=0: q holds. chg=0. sr_err=0.
- qbar always equals ~q. It is a registered copy, never combinational, and there is no cycle where qbar==q.
- chg = q_next ^ q_current, registered alongside q (load and en paths included).
- sr_err=1 for exactly the cycle after an edge where en=1, load=0, mode=11 and any bit had j&k=1. It is 0 otherwise.
- err_sticky: set when sr_err is set. Cleared by clr_err=1 unless sr_err is being set on that same edge; set wins.
- chg_cnt: +1 on each edge where chg becomes nonzero. Saturates at 2^CNT_W−1 with no wrap. Only rst clears it.

## Timing
- Latency: every output reflects inputs sampled at edge n from edge n onward, one cycle. There are no combinational input→output paths.
- Mode may change every cycle. The new mode applies at the very next edge, with no pipeline drain.
- rst asserted mid-operation wins on that edge. On the first edge after rst deasserts, normal operation resumes using the inputs sampled then.
- load and en both 1: load wins. No sr_err even if mode=11 with j&k≠0.
- When the counter is saturated, further changes keep chg_cnt at max and still update chg.

## Test plan
- Reset, WIDTH=8, RESET_VAL=8'hA5: rst=1 for 2 cycles → q=A5, qbar=5A, chg=0, chg_cnt=0, sr_err=0, err_sticky=0.
- JK from q=00, en=1: j=FF,k=00 → q=FF, chg=FF, chg_cnt=1. Then j=FF,k=FF → q=00. Then j=0F,k=F0 → q=0F, chg_cnt=3.
- T/D, mode switching: from q=0F, mode=10 with j=FF → q=F0. Next cycle mode=01 with j=3C → q=3C. Next cycle en=0 → q holds 3C, chg=00, chg_cnt unchanged.
- SR illegal: mode=11, q=00, j=81, k=01 → q=80, sr_err=1 for one cycle, err_sticky=1. clr_err alone → err_sticky=0. clr_err on the same edge as a new illegal input → err_sticky stays 1.
- Load priority: en=1, mode=11, j=k=FF, load=1, load_val=5A → q=5A, sr_err=0. Then rst=1 together with load=1 → q=RESET_VAL.
- Saturation, CNT_W=2: four consecutive toggling edges (T mode, j=01) → chg_cnt goes 1,2,3,3, and chg=01 on every edge.

Source files
------------

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: bank of WIDTH flip-flops. A shared mode input makes every bit
// behave as a JK, D, T or SR flip-flop. The bank also provides parallel load,
// SR-illegal detection with a sticky flag, and a saturating change counter.
// Every output is registered.
module jk_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] chg,
  output logic             sr_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [1:0]       MODE_JK = 2'b00;
  localparam logic [1:0]       MODE_D  = 2'b01;
  localparam logic [1:0]       MODE_T  = 2'b10;
  localparam logic [1:0]       MODE_SR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qbar_r;
  logic [WIDTH-1:0] chg_r;
  logic             sr_err_r;
  logic             err_sticky_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] diff_s;
  logic             sr_illegal_s;

  // Next-state selection: load beats enable, enable applies the per-mode rule.
  always_comb begin
    q_next_s     = q_r;
    sr_illegal_s = 1'b0;
    if (load) begin
      q_next_s = load_val;
    end else if (en) begin
      case (mode)
        // JK: set where j & ~q, keep where ~k & q (11 toggles, 01 clears).
        MODE_JK: q_next_s = (j & ~q_r) | (~k & q_r);
        MODE_D:  q_next_s = j;
        MODE_T:  q_next_s = q_r ^ j;
        // SR: s-only sets, r-only clears, 00 and the illegal 11 both hold.
        MODE_SR: begin
          q_next_s     = (q_r & ~(k & ~j)) | (j & ~k);
          sr_illegal_s = |(j & k);
        end
        default: q_next_s = q_r;
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  assign diff_s = q_next_s ^ q_r;

  // State, complement and per-bit change flags are registered side by side,
  // so qbar never disagrees with q on any cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= RESET_VAL;
      qbar_r <= ~RESET_VAL;
      chg_r  <= {WIDTH{1'b0}};
    end else begin
      q_r    <= q_next_s;
      qbar_r <= ~q_next_s;
      chg_r  <= diff_s;
    end
  end

  // SR-illegal pulse and its sticky copy; a new error beats a clear on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_err_r     <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      sr_err_r <= sr_illegal_s;
      if (sr_illegal_s) begin
        err_sticky_r <= 1'b1;
      end else if (clr_err) begin
        err_sticky_r <= 1'b0;
      end else begin
        err_sticky_r <= err_sticky_r;
      end
    end
  end

  // Saturating count of edges on which any bit of q changed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((|diff_s) && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q          = q_r;
  assign qbar       = qbar_r;
  assign chg        = chg_r;
  assign sr_err     = sr_err_r;
  assign err_sticky = err_sticky_r;
  assign chg_cnt    = cnt_r;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed testbench for jk_ff_bank. The bench has two instances that share
// the same inputs:
//   dut  - RESET_VAL = 8'hA5, 16-bit counter
//   dut2 - RESET_VAL = 8'h00, 2-bit counter, used to check saturation
module tb_jk_ff_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic       load;
  logic [7:0] load_val;
  logic       clr_err;

  logic [7:0]  q;
  logic [7:0]  qbar;
  logic [7:0]  chg;
  logic        sr_err;
  logic        err_sticky;
  logic [15:0] chg_cnt;

  logic [7:0] q2;
  logic [7:0] qbar2;
  logic [7:0] chg2;
  logic       sr_err2;
  logic       err_sticky2;
  logic [1:0] chg_cnt2;

  int checks;
  int failures;

  jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .q(q), .qbar(qbar), .chg(chg), .sr_err(sr_err),
    .err_sticky(err_sticky), .chg_cnt(chg_cnt)
  );

  jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .q(q2), .qbar(qbar2), .chg(chg2), .sr_err(sr_err2),
    .err_sticky(err_sticky2), .chg_cnt(chg_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b00; j = 8'hFF; k = 8'h00;
    load = 1'b0; load_val = 8'h00; clr_err = 1'b0;
    tick();
    tick();
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL reset_q got=%h exp=a5", q); end
    checks++; if (qbar !== 8'h5A) begin failures++; $display("FAIL reset_qbar got=%h exp=5a", qbar); end
    checks++; if (chg !== 8'h00) begin failures++; $display("FAIL reset_chg got=%h exp=00", chg); end
    checks++; if (chg_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", chg_cnt); end
    checks++; if (sr_err !== 1'b0) begin failures++; $display("FAIL reset_sr_err got=%b exp=0", sr_err); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b exp=0", err_sticky); end
    checks++; if (q2 !== 8'h00) begin failures++; $display("FAIL reset_q2 got=%h exp=00", q2); end
  endtask

  task automatic test_jk();
    // Bring q to 00 via load: A5 -> 00 counts as one change.
    rst = 1'b0; en = 1'b0; load = 1'b1; load_val = 8'h00;
    tick();
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL load00_q got=%h exp=00", q); end
    checks++; if (chg !== 8'hA5) begin failures++; $display("FAIL load00_chg got=%h exp=a5", chg); end
    checks++; if (chg_cnt !== 16'd1) begin failures++; $display("FAIL load00_cnt got=%0d exp=1", chg_cnt); end
    checks++; if (chg_cnt2 !== 2'd0) begin failures++; $display("FAIL load00_cnt2 got=%0d exp=0", chg_cnt2); end
    load = 1'b0; en = 1'b1; mode = 2'b00; j = 8'hFF; k = 8'h00;
    tick();
    checks++; if (q !== 8'hFF) begin failures++; $display("FAIL jk_set_q got=%h exp=ff", q); end
    checks++; if (qbar !== 8'h00) begin failures++; $display("FAIL jk_set_qbar got=%h exp=00", qbar); end
    checks++; if (chg !== 8'hFF) begin failures++; $display("FAIL jk_set_chg got=%h exp=ff", chg); end
    checks++; if (chg_cnt !== 16'd2) begin failures++; $display("FAIL jk_set_cnt got=%0d exp=2", chg_cnt); end
    checks++; if (chg_cnt2 !== 2'd1) begin failures++; $display("FAIL jk_set_cnt2 got=%0d exp=1", chg_cnt2); end
    j = 8'hFF; k = 8'hFF;
    tick();
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL jk_toggle_q got=%h exp=00", q); end
    checks++; if (chg !== 8'hFF) begin failures++; $display("FAIL jk_toggle_chg got=%h exp=ff", chg); end
    j = 8'h0F; k = 8'hF0;
    tick();
    checks++; if (q !== 8'h0F) begin failures++; $display("FAIL jk_mixed_q got=%h exp=0f", q); end
    checks++; if (chg !== 8'h0F) begin failures++; $display("FAIL jk_mixed_chg got=%h exp=0f", chg); end
    checks++; if (chg_cnt !== 16'd4) begin failures++; $display("FAIL jk_mixed_cnt got=%0d exp=4", chg_cnt); end
    checks++; if (chg_cnt2 !== 2'd3) begin failures++; $display("FAIL jk_mixed_cnt2 got=%0d exp=3", chg_cnt2); end
  endtask

  task automatic test_mode_switch();
    mode = 2'b10; j = 8'hFF; k = 8'h00;
    tick();
    checks++; if (q !== 8'hF0) begin failures++; $display("FAIL t_q got=%h exp=f0", q); end
    checks++; if (qbar !== 8'h0F) begin failures++; $display("FAIL t_qbar got=%h exp=0f", qbar); end
    checks++; if (chg !== 8'hFF) begin failures++; $display("FAIL t_chg got=%h exp=ff", chg); end
    mode = 2'b01; j = 8'h3C; k = 8'hFF;
    tick();
    checks++; if (q !== 8'h3C) begin failures++; $display("FAIL d_q got=%h exp=3c", q); end
    checks++; if (chg !== 8'hCC) begin failures++; $display("FAIL d_chg got=%h exp=cc", chg); end
    checks++; if (chg_cnt !== 16'd6) begin failures++; $display("FAIL d_cnt got=%0d exp=6", chg_cnt); end
    en = 1'b0; j = 8'h00;
    tick();
    checks++; if (q !== 8'h3C) begin failures++; $display("FAIL hold_q got=%h exp=3c", q); end
    checks++; if (chg !== 8'h00) begin failures++; $display("FAIL hold_chg got=%h exp=00", chg); end
    checks++; if (chg_cnt !== 16'd6) begin failures++; $display("FAIL hold_cnt got=%0d exp=6", chg_cnt); end
  endtask

  task automatic test_sr();
    load = 1'b1; load_val = 8'h00;
    tick();
    load = 1'b0; en = 1'b1; mode = 2'b11; j = 8'h81; k = 8'h01;
    tick();
    checks++; if (q !== 8'h80) begin failures++; $display("FAIL sr_q got=%h exp=80", q); end
    checks++; if (chg !== 8'h80) begin failures++; $display("FAIL sr_chg got=%h exp=80", chg); end
    checks++; if (chg_cnt !== 16'd8) begin failures++; $display("FAIL sr_cnt got=%0d exp=8", chg_cnt); end
    checks++; if (sr_err !== 1'b1) begin failures++; $display("FAIL sr_err_pulse got=%b exp=1", sr_err); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL sr_sticky_set got=%b exp=1", err_sticky); end
    en = 1'b0;
    tick();
    checks++; if (sr_err !== 1'b0) begin failures++; $display("FAIL sr_err_one_cycle got=%b exp=0", sr_err); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL sr_sticky_hold got=%b exp=1", err_sticky); end
    clr_err = 1'b1;
    tick();
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL sr_sticky_clr got=%b exp=0", err_sticky); end
    en = 1'b1; j = 8'h01; k = 8'h01;
    tick();
    checks++; if (q !== 8'h80) begin failures++; $display("FAIL sr_illegal_hold_q got=%h exp=80", q); end
    checks++; if (sr_err !== 1'b1) begin failures++; $display("FAIL sr_err_again got=%b exp=1", sr_err); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL sr_set_beats_clr got=%b exp=1", err_sticky); end
    clr_err = 1'b0;
  endtask

  task automatic test_load_priority();
    en = 1'b1; mode = 2'b11; j = 8'hFF; k = 8'hFF; load = 1'b1; load_val = 8'h5A;
    tick();
    checks++; if (q !== 8'h5A) begin failures++; $display("FAIL ldpri_q got=%h exp=5a", q); end
    checks++; if (qbar !== 8'hA5) begin failures++; $display("FAIL ldpri_qbar got=%h exp=a5", qbar); end
    checks++; if (chg !== 8'hDA) begin failures++; $display("FAIL ldpri_chg got=%h exp=da", chg); end
    checks++; if (sr_err !== 1'b0) begin failures++; $display("FAIL ldpri_sr_err got=%b exp=0", sr_err); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL ldpri_sticky got=%b exp=1", err_sticky); end
    rst = 1'b1;
    tick();
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL rstpri_q got=%h exp=a5", q); end
    checks++; if (chg_cnt !== 16'd0) begin failures++; $display("FAIL rstpri_cnt got=%0d exp=0", chg_cnt); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL rstpri_sticky got=%b exp=0", err_sticky); end
    checks++; if (chg !== 8'h00) begin failures++; $display("FAIL rstpri_chg got=%h exp=00", chg); end
  endtask

  task automatic test_saturation();
    logic [1:0]  exp_cnt2 [4];
    logic [7:0]  exp_q2   [4];
    logic [7:0]  exp_q    [4];
    exp_cnt2 = '{2'd1, 2'd2, 2'd3, 2'd3};
    exp_q2   = '{8'h01, 8'h00, 8'h01, 8'h00};
    exp_q    = '{8'hA4, 8'hA5, 8'hA4, 8'hA5};
    rst = 1'b0; load = 1'b0; en = 1'b1; mode = 2'b10; j = 8'h01; k = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (chg_cnt2 !== exp_cnt2[i]) begin failures++; $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", i, chg_cnt2, exp_cnt2[i]); end
      checks++; if (chg2 !== 8'h01) begin failures++; $display("FAIL sat_chg2[%0d] got=%h exp=01", i, chg2); end
      checks++; if (q2 !== exp_q2[i]) begin failures++; $display("FAIL sat_q2[%0d] got=%h exp=%h", i, q2, exp_q2[i]); end
      checks++; if (q !== exp_q[i]) begin failures++; $display("FAIL sat_q[%0d] got=%h exp=%h", i, q, exp_q[i]); end
      checks++; if (chg_cnt !== 16'(i + 1)) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, chg_cnt, i + 1); end
      checks++; if (qbar !== ~exp_q[i]) begin failures++; $display("FAIL sat_qbar[%0d] got=%h exp=%h", i, qbar, ~exp_q[i]); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; en = 1'b0; mode = 2'b00; j = 8'h00; k = 8'h00;
    load = 1'b0; load_val = 8'h00; clr_err = 1'b0;
    test_reset();
    test_jk();
    test_mode_switch();
    test_sr();
    test_load_priority();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
